xcore_id_exe_stage: RTL and testbench
=====================================

Name: xcore_id_exe_stage

Overview:
- ID/EXE pipeline register and operand-forwarding stage that directly feeds the EXE ALU.
- Captures a decoded instruction from ID and holds it under a valid/ready handshake.
- Resolves RAW hazards by forwarding from MEM/WB and by a load-use bubble.
- Drives the ALU control lines (aluctrl, a_l, l_r, u_s, sub_add) and operands (data_a, data_b).

Parameters:
- XLEN, 32, datapath width; matches `WIDTH in params.v.
- RA_W, 5, register-address width.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  kill the instruction held in EXE (branch/exception).
- id_valid  in  1  ID presents an instruction.
- id_ready  out  1  stage accepts this cycle.
- id_aluctrl  in  3  ALU result select.
- id_a_l, id_l_r, id_u_s, id_sub_add  in  1 each  ALU shift/sign/sub controls.
- id_pc  in  XLEN  instruction PC.
- id_imm  in  XLEN  immediate.
- id_use_pc  in  1  operand A = PC.
- id_use_imm  in  1  operand B = imm.
- id_rs1_addr, id_rs2_addr  in  RA_W  source registers.
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data.
- id_rd_addr  in  RA_W  destination register.
- id_rd_we  in  1  writes rd.
- id_is_load  in  1  memory load.
- ex_ready  in  1  EXE/MEM can take the held instruction.
- mem_rd_addr  in  RA_W  MEM destination.
- mem_rd_we  in  1  MEM write enable.
- mem_fwd_data  in  XLEN  MEM result (loads included).
- wb_rd_addr  in  RA_W  WB destination.
- wb_rd_we  in  1  WB write enable.
- wb_data  in  XLEN  WB result.
- ex_valid  out  1  held instruction valid.
- aluctrl  out  3  to ALU.
- a_l, l_r, u_s, sub_add  out  1 each  to ALU.
- data_a, data_b  out  XLEN  ALU operands.
- ex_store_data  out  XLEN  forwarded rs2 for stores.
- ex_rd_addr  out  RA_W  destination register.
- ex_rd_we  out  1  gated by ex_valid.
- ex_is_load  out  1  gated by ex_valid.
- load_use_stall  out  1  bubble inserted this cycle.

Behaviour:
- Reset (async, rst_n=0): every register cleared, so ex_valid=0 and all outputs are 0.
- Capture occurs when id_valid & id_ready. The register is written at the next rising edge, giving 1-cycle latency from ID to ALU inputs.
- Hazard: hz = ex_valid & ex_is_load & ex_rd_we & ex_rd_addr!=0 & (id_rs1_addr==ex_rd_addr | id_rs2_addr==ex_rd_addr).
- id_ready = (!ex_valid | ex_ready) & !hz.
- load_use_stall = id_valid & hz.
- Next-state priority, per rising edge:
  1. flush → ex_valid←0; any simultaneous ID handshake is dropped.
  2. capture → load all fields, ex_valid←1.
  3. ex_ready & !capture → ex_valid←0 (bubble; covers hz).
  4. otherwise hold.
- Held-operand refresh: while holding, if wb_rd_we & wb_rd_addr!=0 matches a stored rs address, the stored raw rs data is overwritten with wb_data. A value forwarded from WB therefore survives stall cycles.
- Forwarding (combinational on stored rs address), per operand: x0 reads 0. Otherwise MEM match (mem_rd_we) takes priority, then WB match, then stored data.
- data_a = use_pc ? pc : fwd_rs1.
- data_b = use_imm ? imm : fwd_rs2.
- ex_store_data = fwd_rs2.
- When ex_valid=0, control outputs remain at their last values. ex_rd_we, ex_is_load and load_use-relevant state are forced 0.
- Reset asserted mid-stall clears immediately; no instruction is replayed.

Optional Feature:
- Macro XCORE_FWD_EN.
- Defined: MEM/WB forwarding and refresh as above.
- Undefined: no forwarding muxes; operands come straight from stored rs data. hz additionally asserts on any rs match (addr!=0) against EXE (ex_rd_we & ex_valid), MEM (mem_rd_we) or WB (wb_rd_we), stalling ID until the producer has retired.

Decomposition:
- params.v holds `WIDTH, RA_W, the ALU ctrl encodings (ADD=000, SHIFT=001, SLT=010, PASSB=011, XOR=100, AND=101, OR=110) and XCORE_FWD_EN.
- Sub-module xcore_exe_fwd_mux: one instance per rs, taking addr/stored data/MEM/WB and returning the forwarded value.

Test Plan:
1. Reset mid-hold with ex_valid=1 → all outputs 0 within the same cycle, ex_valid=0.
2. ADD x3,x1,x2 (rs1=5, rs2=7), ex_ready=1 → next cycle aluctrl=000, data_a=5, data_b=7, ex_rd_we=1.
3. MEM writes x1=0x11 and WB writes x1=0x22 simultaneously; EXE rs1=x1 → data_a=0x11. With XCORE_FWD_EN off, an ID instruction reading x1 stalls (id_ready=0).
4. LW x4 in EXE, ID ADD x5,x4,x0 → load_use_stall=1, id_ready=0 for one cycle. Next cycle ex_valid=0 (bubble). Then ADD is captured and data_a=mem_fwd_data.
5. ex_ready=0 for 3 cycles while WB writes rs2=x6=0xAB → after release, data_b=0xAB. rs=x0 with WB writing x0 → operand stays 0.
6. flush with id_valid=1 and id_ready=1 → ex_valid=0 next cycle, ex_rd_we=0, and the ID instruction is not executed.

Source files
------------

// File: rtl/xcore_id_exe_stage_pkg.sv
// Shared types for the ID/EXE stage: widths, ALU select encodings, the
// held-instruction payload and the register-match helper.
package xcore_id_exe_stage_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned RA_W   = 5;
   localparam int unsigned CTRL_W = 3;

   typedef enum logic [CTRL_W-1:0] {
      ALU_ADD   = 3'b000,
      ALU_SHIFT = 3'b001,
      ALU_SLT   = 3'b010,
      ALU_PASSB = 3'b011,
      ALU_XOR   = 3'b100,
      ALU_AND   = 3'b101,
      ALU_OR    = 3'b110
   } alu_ctrl_e;

   // Decoded instruction as held in the ID/EXE register.
   typedef struct packed {
      alu_ctrl_e        aluctrl;
      logic             a_l;
      logic             l_r;
      logic             u_s;
      logic             sub_add;
      logic [XLEN-1:0]  pc;
      logic [XLEN-1:0]  imm;
      logic             use_pc;
      logic             use_imm;
      logic [RA_W-1:0]  rs1_addr;
      logic [RA_W-1:0]  rs2_addr;
      logic [XLEN-1:0]  rs1_data;
      logic [XLEN-1:0]  rs2_data;
      logic [RA_W-1:0]  rd_addr;
      logic             rd_we;
      logic             is_load;
   } id_exe_t;

   // True when a writer of rd (x0 never counts) produces source register rs.
   function automatic logic rs_hit(input logic [RA_W-1:0] rs,
                                   input logic [RA_W-1:0] rd,
                                   input logic            we);
      return we && (rd != '0) && (rs == rd);
   endfunction

endpackage

// File: rtl/xcore_id_exe_stage_if.sv
// ID/EXE stage bundle: ID request side, MEM/WB bypass sources and the
// EXE/ALU-facing outputs.
// slave  : the stage (consumes ID/MEM/WB, drives id_ready and EXE outputs).
// master : the surrounding pipeline / environment.
interface xcore_id_exe_stage_if;
   import xcore_id_exe_stage_pkg::*;

   logic              flush;
   logic              id_valid;
   logic              id_ready;
   logic [CTRL_W-1:0] id_aluctrl;
   logic              id_a_l, id_l_r, id_u_s, id_sub_add;
   logic [XLEN-1:0]   id_pc, id_imm;
   logic              id_use_pc, id_use_imm;
   logic [RA_W-1:0]   id_rs1_addr, id_rs2_addr;
   logic [XLEN-1:0]   id_rs1_data, id_rs2_data;
   logic [RA_W-1:0]   id_rd_addr;
   logic              id_rd_we, id_is_load;
   logic              ex_ready;
   logic [RA_W-1:0]   mem_rd_addr;
   logic              mem_rd_we;
   logic [XLEN-1:0]   mem_fwd_data;
   logic [RA_W-1:0]   wb_rd_addr;
   logic              wb_rd_we;
   logic [XLEN-1:0]   wb_data;
   logic              ex_valid;
   logic [CTRL_W-1:0] aluctrl;
   logic              a_l, l_r, u_s, sub_add;
   logic [XLEN-1:0]   data_a, data_b, ex_store_data;
   logic [RA_W-1:0]   ex_rd_addr;
   logic              ex_rd_we, ex_is_load;
   logic              load_use_stall;

   modport slave (
      input  flush, id_valid, id_aluctrl, id_a_l, id_l_r, id_u_s, id_sub_add,
             id_pc, id_imm, id_use_pc, id_use_imm, id_rs1_addr, id_rs2_addr,
             id_rs1_data, id_rs2_data, id_rd_addr, id_rd_we, id_is_load,
             ex_ready, mem_rd_addr, mem_rd_we, mem_fwd_data,
             wb_rd_addr, wb_rd_we, wb_data,
      output id_ready, ex_valid, aluctrl, a_l, l_r, u_s, sub_add,
             data_a, data_b, ex_store_data, ex_rd_addr, ex_rd_we, ex_is_load,
             load_use_stall
   );

   modport master (
      output flush, id_valid, id_aluctrl, id_a_l, id_l_r, id_u_s, id_sub_add,
             id_pc, id_imm, id_use_pc, id_use_imm, id_rs1_addr, id_rs2_addr,
             id_rs1_data, id_rs2_data, id_rd_addr, id_rd_we, id_is_load,
             ex_ready, mem_rd_addr, mem_rd_we, mem_fwd_data,
             wb_rd_addr, wb_rd_we, wb_data,
      input  id_ready, ex_valid, aluctrl, a_l, l_r, u_s, sub_add,
             data_a, data_b, ex_store_data, ex_rd_addr, ex_rd_we, ex_is_load,
             load_use_stall
   );

endinterface

// File: rtl/xcore_exe_fwd_mux.sv
// Operand bypass for one source register: x0 reads 0, then MEM, then WB,
// then the stored register-file value.
// Ports: rs_addr_i/rs_data_i (held operand), mem_*_i / wb_*_i (producers),
//        fwd_data_c_o (combinational forwarded operand).
module xcore_exe_fwd_mux
   import xcore_id_exe_stage_pkg::*;
(
   input  logic [RA_W-1:0] rs_addr_i,
   input  logic [XLEN-1:0] rs_data_i,
   input  logic [RA_W-1:0] mem_rd_addr_i,
   input  logic            mem_rd_we_i,
   input  logic [XLEN-1:0] mem_data_i,
   input  logic [RA_W-1:0] wb_rd_addr_i,
   input  logic            wb_rd_we_i,
   input  logic [XLEN-1:0] wb_data_i,
   output logic [XLEN-1:0] fwd_data_c_o
);

   always_comb begin
      fwd_data_c_o = rs_data_i;
      if (rs_addr_i == '0)
         fwd_data_c_o = '0;
      else if (rs_hit(rs_addr_i, mem_rd_addr_i, mem_rd_we_i))
         fwd_data_c_o = mem_data_i;
      else if (rs_hit(rs_addr_i, wb_rd_addr_i, wb_rd_we_i))
         fwd_data_c_o = wb_data_i;
   end

endmodule

// File: rtl/xcore_id_exe_stage.sv
// ID/EXE pipeline register with operand forwarding feeding the EXE ALU.
// Holds one decoded instruction under a valid/ready handshake, inserts a
// load-use bubble and drives ALU controls/operands.
// Ports: clk, rst_n (async active-low), bus (xcore_id_exe_stage_if.slave).
// Build option: XCORE_FWD_EN enables MEM/WB bypass and held-operand refresh;
// without it ID stalls on any in-flight producer of its sources.
module xcore_id_exe_stage
   import xcore_id_exe_stage_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   xcore_id_exe_stage_if.slave   bus
);

   id_exe_t          st_q, st_d, id_pkt;
   logic             valid_q, valid_d;
   logic             hz, hz_lu, capture;
   logic             mem_fwd_we, wb_fwd_we;
   logic [XLEN-1:0]  rs1_fwd, rs2_fwd;

   // Pack the ID request into the held-instruction format.
   always_comb begin
      id_pkt          = '0;
      id_pkt.aluctrl  = alu_ctrl_e'(bus.id_aluctrl);
      id_pkt.a_l      = bus.id_a_l;
      id_pkt.l_r      = bus.id_l_r;
      id_pkt.u_s      = bus.id_u_s;
      id_pkt.sub_add  = bus.id_sub_add;
      id_pkt.pc       = bus.id_pc;
      id_pkt.imm      = bus.id_imm;
      id_pkt.use_pc   = bus.id_use_pc;
      id_pkt.use_imm  = bus.id_use_imm;
      id_pkt.rs1_addr = bus.id_rs1_addr;
      id_pkt.rs2_addr = bus.id_rs2_addr;
      id_pkt.rs1_data = bus.id_rs1_data;
      id_pkt.rs2_data = bus.id_rs2_data;
      id_pkt.rd_addr  = bus.id_rd_addr;
      id_pkt.rd_we    = bus.id_rd_we;
      id_pkt.is_load  = bus.id_is_load;
   end

   // A load in EXE cannot be bypassed to the instruction in ID.
   assign hz_lu = valid_q && st_q.is_load &&
                  (rs_hit(bus.id_rs1_addr, st_q.rd_addr, st_q.rd_we) ||
                   rs_hit(bus.id_rs2_addr, st_q.rd_addr, st_q.rd_we));

`ifdef XCORE_FWD_EN
   assign hz         = hz_lu;
   assign mem_fwd_we = bus.mem_rd_we;
   assign wb_fwd_we  = bus.wb_rd_we;
`else
   // Without bypass, wait until no stage still owes a source register.
   assign hz = hz_lu ||
      rs_hit(bus.id_rs1_addr, st_q.rd_addr, valid_q && st_q.rd_we) ||
      rs_hit(bus.id_rs2_addr, st_q.rd_addr, valid_q && st_q.rd_we) ||
      rs_hit(bus.id_rs1_addr, bus.mem_rd_addr, bus.mem_rd_we) ||
      rs_hit(bus.id_rs2_addr, bus.mem_rd_addr, bus.mem_rd_we) ||
      rs_hit(bus.id_rs1_addr, bus.wb_rd_addr, bus.wb_rd_we) ||
      rs_hit(bus.id_rs2_addr, bus.wb_rd_addr, bus.wb_rd_we);
   assign mem_fwd_we = 1'b0;
   assign wb_fwd_we  = 1'b0;
`endif

   assign bus.id_ready       = (!valid_q || bus.ex_ready) && !hz;
   assign bus.load_use_stall = bus.id_valid && hz;
   assign capture            = bus.id_valid && bus.id_ready;

   // Next state: flush > capture > drain (bubble) > hold.
   always_comb begin
      st_d    = st_q;
      valid_d = valid_q;
`ifdef XCORE_FWD_EN
      // Keep a WB result seen during a hold, since WB moves on next cycle.
      if (rs_hit(st_q.rs1_addr, bus.wb_rd_addr, bus.wb_rd_we))
         st_d.rs1_data = bus.wb_data;
      if (rs_hit(st_q.rs2_addr, bus.wb_rd_addr, bus.wb_rd_we))
         st_d.rs2_data = bus.wb_data;
`endif
      if (bus.flush) begin
         valid_d = 1'b0;
      end else if (capture) begin
         st_d    = id_pkt;
         valid_d = 1'b1;
      end else if (bus.ex_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q    <= '0;
         valid_q <= 1'b0;
      end else begin
         st_q    <= st_d;
         valid_q <= valid_d;
      end
   end

   xcore_exe_fwd_mux u_fwd_rs1 (
      .rs_addr_i     (st_q.rs1_addr),
      .rs_data_i     (st_q.rs1_data),
      .mem_rd_addr_i (bus.mem_rd_addr),
      .mem_rd_we_i   (mem_fwd_we),
      .mem_data_i    (bus.mem_fwd_data),
      .wb_rd_addr_i  (bus.wb_rd_addr),
      .wb_rd_we_i    (wb_fwd_we),
      .wb_data_i     (bus.wb_data),
      .fwd_data_c_o  (rs1_fwd)
   );

   xcore_exe_fwd_mux u_fwd_rs2 (
      .rs_addr_i     (st_q.rs2_addr),
      .rs_data_i     (st_q.rs2_data),
      .mem_rd_addr_i (bus.mem_rd_addr),
      .mem_rd_we_i   (mem_fwd_we),
      .mem_data_i    (bus.mem_fwd_data),
      .wb_rd_addr_i  (bus.wb_rd_addr),
      .wb_rd_we_i    (wb_fwd_we),
      .wb_data_i     (bus.wb_data),
      .fwd_data_c_o  (rs2_fwd)
   );

   assign bus.ex_valid      = valid_q;
   assign bus.aluctrl       = st_q.aluctrl;
   assign bus.a_l           = st_q.a_l;
   assign bus.l_r           = st_q.l_r;
   assign bus.u_s           = st_q.u_s;
   assign bus.sub_add       = st_q.sub_add;
   assign bus.data_a        = st_q.use_pc  ? st_q.pc  : rs1_fwd;
   assign bus.data_b        = st_q.use_imm ? st_q.imm : rs2_fwd;
   assign bus.ex_store_data = rs2_fwd;
   assign bus.ex_rd_addr    = st_q.rd_addr;
   assign bus.ex_rd_we      = valid_q && st_q.rd_we;
   assign bus.ex_is_load    = valid_q && st_q.is_load;

endmodule

// File: tb/tb_xcore_id_exe_stage.sv
// Directed bench for xcore_id_exe_stage; expectations follow the build
// selected by XCORE_FWD_EN.
module tb_xcore_id_exe_stage;
   import xcore_id_exe_stage_pkg::*;

   logic clk;
   logic rst_n;
   int unsigned n_cmp;
   int unsigned n_err;

   xcore_id_exe_stage_if bus();

   xcore_id_exe_stage dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic id_drive(input logic [2:0] ctrl, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                           input logic we, input logic ld);
      bus.id_valid    = 1'b1;
      bus.id_aluctrl  = ctrl;
      bus.id_a_l      = 1'b0;
      bus.id_l_r      = 1'b0;
      bus.id_u_s      = 1'b0;
      bus.id_sub_add  = 1'b0;
      bus.id_pc       = '0;
      bus.id_imm      = '0;
      bus.id_use_pc   = 1'b0;
      bus.id_use_imm  = 1'b0;
      bus.id_rs1_addr = rs1;
      bus.id_rs2_addr = rs2;
      bus.id_rs1_data = d1;
      bus.id_rs2_data = d2;
      bus.id_rd_addr  = rd;
      bus.id_rd_we    = we;
      bus.id_is_load  = ld;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      bus.flush = 1'b0;
      bus.ex_ready = 1'b0;
      id_drive(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
      bus.id_valid = 1'b0;
      bus.mem_rd_addr = '0; bus.mem_rd_we = 1'b0; bus.mem_fwd_data = '0;
      bus.wb_rd_addr = '0;  bus.wb_rd_we = 1'b0;  bus.wb_data = '0;
      #2;
      chk("rst_ex_valid", 32'(bus.ex_valid), 32'h0);
      chk("rst_data_a", bus.data_a, 32'h0);
      chk("rst_data_b", bus.data_b, 32'h0);
      chk("rst_aluctrl", 32'(bus.aluctrl), 32'h0);
      chk("rst_rd_we", 32'(bus.ex_rd_we), 32'h0);
      chk("rst_is_load", 32'(bus.ex_is_load), 32'h0);
      chk("rst_store", bus.ex_store_data, 32'h0);
      chk("rst_lus", 32'(bus.load_use_stall), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // ADD x3,x1,x2 with 5 and 7
      id_drive(3'b000, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 1'b1, 1'b0);
      bus.ex_ready = 1'b1;
      settle();
      chk("add_id_ready", 32'(bus.id_ready), 32'h1);
      tick();
      bus.id_valid = 1'b0;
      bus.ex_ready = 1'b0;
      settle();
      chk("add_valid", 32'(bus.ex_valid), 32'h1);
      chk("add_aluctrl", 32'(bus.aluctrl), 32'h0);
      chk("add_data_a", bus.data_a, 32'd5);
      chk("add_data_b", bus.data_b, 32'd7);
      chk("add_rd_we", 32'(bus.ex_rd_we), 32'h1);
      chk("add_rd_addr", 32'(bus.ex_rd_addr), 32'd3);
      chk("add_store", bus.ex_store_data, 32'd7);

      // Reset asserted while holding a valid instruction
      tick();
      chk("hold_valid", 32'(bus.ex_valid), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mrst_valid", 32'(bus.ex_valid), 32'h0);
      chk("mrst_data_a", bus.data_a, 32'h0);
      chk("mrst_data_b", bus.data_b, 32'h0);
      chk("mrst_rd_we", 32'(bus.ex_rd_we), 32'h0);
      chk("mrst_rd_addr", 32'(bus.ex_rd_addr), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // SLT with sub/unsigned controls, then bubble keeps controls
      id_drive(3'b010, 5'd1, 5'd2, 5'd10, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0);
      bus.id_sub_add = 1'b1;
      bus.id_u_s = 1'b1;
      bus.ex_ready = 1'b1;
      tick();
      bus.id_valid = 1'b0;
      settle();
      chk("slt_aluctrl", 32'(bus.aluctrl), 32'h2);
      chk("slt_sub_add", 32'(bus.sub_add), 32'h1);
      chk("slt_u_s", 32'(bus.u_s), 32'h1);
      chk("slt_a_l", 32'(bus.a_l), 32'h0);
      chk("slt_data_a", bus.data_a, 32'hFFFF_FFFF);
      tick();
      chk("bub_valid", 32'(bus.ex_valid), 32'h0);
      chk("bub_rd_we", 32'(bus.ex_rd_we), 32'h0);
      chk("bub_aluctrl", 32'(bus.aluctrl), 32'h2);

      // MEM and WB both write x1; EXE instruction reads x1
      id_drive(3'b000, 5'd1, 5'd0, 5'd7, 32'h99, 32'h0, 1'b1, 1'b0);
      tick();
      bus.id_valid = 1'b0;
      bus.ex_ready = 1'b0;
      bus.mem_rd_addr = 5'd1; bus.mem_rd_we = 1'b1; bus.mem_fwd_data = 32'h11;
      bus.wb_rd_addr = 5'd1;  bus.wb_rd_we = 1'b1;  bus.wb_data = 32'h22;
      settle();
`ifdef XCORE_FWD_EN
      chk("fwd_mem_prio", bus.data_a, 32'h11);
`else
      chk("nofwd_data_a", bus.data_a, 32'h99);
`endif
      id_drive(3'b000, 5'd1, 5'd2, 5'd11, 32'h0, 32'h0, 1'b1, 1'b0);
      bus.ex_ready = 1'b1;
      settle();
`ifdef XCORE_FWD_EN
      chk("raw_id_ready", 32'(bus.id_ready), 32'h1);
      chk("raw_lus", 32'(bus.load_use_stall), 32'h0);
`else
      chk("raw_id_ready", 32'(bus.id_ready), 32'h0);
      chk("raw_lus", 32'(bus.load_use_stall), 32'h1);
`endif
      bus.id_valid = 1'b0;
      bus.mem_rd_we = 1'b0;
      bus.wb_rd_we = 1'b0;
      tick();
      chk("raw_drain", 32'(bus.ex_valid), 32'h0);

      // LW x4 then ADD x5,x4,x0 (load-use)
      id_drive(3'b000, 5'd2, 5'd0, 5'd4, 32'h100, 32'h0, 1'b1, 1'b1);
      bus.id_use_imm = 1'b1;
      bus.id_imm = 32'd4;
      tick();
      id_drive(3'b000, 5'd4, 5'd0, 5'd5, 32'hDEAD, 32'h0, 1'b1, 1'b0);
      settle();
      chk("lw_is_load", 32'(bus.ex_is_load), 32'h1);
      chk("lw_data_a", bus.data_a, 32'h100);
      chk("lw_data_b", bus.data_b, 32'd4);
      chk("lu_stall", 32'(bus.load_use_stall), 32'h1);
      chk("lu_id_ready", 32'(bus.id_ready), 32'h0);
      tick();
      bus.mem_rd_addr = 5'd4; bus.mem_rd_we = 1'b1; bus.mem_fwd_data = 32'h1234;
      settle();
      chk("lu_bubble", 32'(bus.ex_valid), 32'h0);
      chk("lu_bub_load", 32'(bus.ex_is_load), 32'h0);
`ifdef XCORE_FWD_EN
      chk("lu_release", 32'(bus.id_ready), 32'h1);
      tick();
      bus.id_valid = 1'b0;
      bus.mem_rd_we = 1'b0;
      bus.wb_rd_addr = 5'd4; bus.wb_rd_we = 1'b1; bus.wb_data = 32'h1234;
      settle();
`else
      chk("lu_mem_wait", 32'(bus.id_ready), 32'h0);
      tick();
      bus.mem_rd_we = 1'b0;
      bus.wb_rd_addr = 5'd4; bus.wb_rd_we = 1'b1; bus.wb_data = 32'h1234;
      settle();
      chk("lu_wb_wait", 32'(bus.id_ready), 32'h0);
      tick();
      bus.wb_rd_we = 1'b0;
      bus.id_rs1_data = 32'h1234;
      settle();
      chk("lu_release", 32'(bus.id_ready), 32'h1);
      tick();
      bus.id_valid = 1'b0;
      settle();
`endif
      chk("lu_add_valid", 32'(bus.ex_valid), 32'h1);
      chk("lu_add_data_a", bus.data_a, 32'h1234);
      chk("lu_add_rd", 32'(bus.ex_rd_addr), 32'd5);
      bus.wb_rd_we = 1'b0;
      tick();

      // Hold 3 cycles while WB writes x6 then x0
      id_drive(3'b011, 5'd0, 5'd6, 5'd8, 32'h0, 32'h55, 1'b1, 1'b0);
      tick();
      bus.id_valid = 1'b0;
      bus.ex_ready = 1'b0;
      bus.wb_rd_addr = 5'd6; bus.wb_rd_we = 1'b1; bus.wb_data = 32'hAB;
      settle();
      chk("h1_valid", 32'(bus.ex_valid), 32'h1);
      tick();
      bus.wb_rd_addr = 5'd0; bus.wb_data = 32'h77;
      settle();
      chk("h2_x0_data_a", bus.data_a, 32'h0);
      tick();
      bus.wb_rd_we = 1'b0;
      tick();
      bus.ex_ready = 1'b1;
      settle();
      chk("h_valid", 32'(bus.ex_valid), 32'h1);
`ifdef XCORE_FWD_EN
      chk("refresh_data_b", bus.data_b, 32'hAB);
      chk("refresh_store", bus.ex_store_data, 32'hAB);
`else
      chk("hold_data_b", bus.data_b, 32'h55);
      chk("hold_store", bus.ex_store_data, 32'h55);
`endif
      chk("x0_data_a", bus.data_a, 32'h0);
      tick();
      chk("h_drain", 32'(bus.ex_valid), 32'h0);

      // OR with PC/imm operands, then flush against an accepted ID
      id_drive(3'b110, 5'd0, 5'd0, 5'd9, 32'h0, 32'h0, 1'b1, 1'b0);
      bus.id_use_pc = 1'b1;  bus.id_pc = 32'h4000;
      bus.id_use_imm = 1'b1; bus.id_imm = 32'h10;
      tick();
      settle();
      chk("pc_data_a", bus.data_a, 32'h4000);
      chk("imm_data_b", bus.data_b, 32'h10);
      chk("or_aluctrl", 32'(bus.aluctrl), 32'h6);
      id_drive(3'b100, 5'd1, 5'd2, 5'd12, 32'd3, 32'd4, 1'b1, 1'b0);
      bus.flush = 1'b1;
      settle();
      chk("fl_id_ready", 32'(bus.id_ready), 32'h1);
      tick();
      bus.flush = 1'b0;
      bus.id_valid = 1'b0;
      settle();
      chk("fl_valid", 32'(bus.ex_valid), 32'h0);
      chk("fl_rd_we", 32'(bus.ex_rd_we), 32'h0);
      chk("fl_rd_addr", 32'(bus.ex_rd_addr), 32'd9);
      chk("fl_aluctrl", 32'(bus.aluctrl), 32'h6);
      tick();
      chk("fl_stay", 32'(bus.ex_valid), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
